// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with a fill-level count, programmable
// almost-full / almost-empty thresholds, one-cycle overflow / underflow
// pulses and a read-data valid strobe. Read latency is one cycle. When the
// FIFO is full, a simultaneous read and write both complete.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   wr_en        write request
//   rd_en        read request
//   data_in      write data (WIDTH)
//   data_out     registered read data (WIDTH)
//   data_valid   data_out was loaded by a read on the last edge
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        stored words, 0..DEPTH (ADDR+1)
//   overflow     one-cycle pulse: a write was rejected
//   underflow    one-cycle pulse: a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR     = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ADDR:0]    count,
   output logic             overflow,
   output logic             underflow
);

   // Parameter sanity checks, evaluated at elaboration time.
   if (DEPTH != (2 ** ADDR)) begin : g_chk_depth
      $error("sync_fifo_param: DEPTH must equal 2**ADDR");
   end
   if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL < DEPTH))) begin : g_chk_levels
      $error("sync_fifo_param: require 0 < AE_LEVEL < AF_LEVEL < DEPTH");
   end

   localparam logic [ADDR:0]   DEPTH_C   = (ADDR + 1)'(DEPTH);
   localparam logic [ADDR:0]   AF_C      = (ADDR + 1)'(AF_LEVEL);
   localparam logic [ADDR:0]   AE_C      = (ADDR + 1)'(AE_LEVEL);
   localparam logic [ADDR:0]   CNT_ONE_C = (ADDR + 1)'(1);
   localparam logic [ADDR:0]   CNT_ZERO_C = (ADDR + 1)'(0);
   localparam logic [ADDR-1:0] PTR_ONE_C = ADDR'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR-1:0]  wr_ptr_r;
   logic [ADDR-1:0]  rd_ptr_r;
   logic [ADDR:0]    count_r;
   logic [WIDTH-1:0] data_out_r;
   logic             data_valid_r;
   logic             full_r;
   logic             empty_r;
   logic             almost_full_r;
   logic             almost_empty_r;
   logic             overflow_r;
   logic             underflow_r;

   logic             rd_acc_s;
   logic             wr_acc_s;
   logic [ADDR:0]    count_nxt_s;

   // Accept decisions and next fill level; flags are derived from the next
   // level so they move on the same edge as count.
   always_comb begin
      rd_acc_s    = 1'b0;
      wr_acc_s    = 1'b0;
      count_nxt_s = count_r;
      rd_acc_s = rd_en && !empty_r;
      // A read on the same edge frees a slot, so a write into a full FIFO
      // still succeeds.
      wr_acc_s = wr_en && (!full_r || rd_acc_s);
      if (wr_acc_s && !rd_acc_s) begin
         count_nxt_s = count_r + CNT_ONE_C;
      end else if (rd_acc_s && !wr_acc_s) begin
         count_nxt_s = count_r - CNT_ONE_C;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Storage array; deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Pointers, count, read data and all registered flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         count_r        <= '0;
         data_out_r     <= '0;
         data_valid_r   <= 1'b0;
         full_r         <= 1'b0;
         empty_r        <= 1'b1;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
         overflow_r     <= 1'b0;
         underflow_r    <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (rd_acc_s) begin
            rd_ptr_r   <= rd_ptr_r + PTR_ONE_C;
            data_out_r <= mem_r[rd_ptr_r];
         end
         data_valid_r   <= rd_acc_s;
         count_r        <= count_nxt_s;
         full_r         <= (count_nxt_s == DEPTH_C);
         empty_r        <= (count_nxt_s == CNT_ZERO_C);
         almost_full_r  <= (count_nxt_s >= AF_C);
         almost_empty_r <= (count_nxt_s <= AE_C);
         overflow_r     <= wr_en && !wr_acc_s;
         underflow_r    <= rd_en && !rd_acc_s;
      end
   end

   assign data_out     = data_out_r;
   assign data_valid   = data_valid_r;
   assign full         = full_r;
   assign empty        = empty_r;
   assign almost_full  = almost_full_r;
   assign almost_empty = almost_empty_r;
   assign count        = count_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the fixed 8x8 FIFO. It adds a fill-level count, programmable almost-full and almost-empty thresholds, sticky-free overflow and underflow pulses, and a read-data valid strobe. It supports simultaneous read and write in every state, including full. It is a single-clock buffer between a producer and a consumer in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; must equal 2**ADDR
ADDR, 4, pointer width, log2(DEPTH)
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write request, sampled on rising clock
rd_en  input  1  read request, sampled on rising clock
data_in  input  WIDTH  write data
data_out  output  WIDTH  registered read data
data_valid  output  1  data_out was updated by a read on the last edge
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR+1  current number of stored words, range 0..DEPTH
overflow  output  1  one-cycle pulse: a write was rejected
underflow  output  1  one-cycle pulse: a read was rejected

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - Write/read pointers, count, data_out, data_valid, full, overflow and underflow clear to 0.
  - empty=1, almost_empty=1, almost_full=0.
  - Memory array is not cleared.
  - Reset asserted mid-burst discards all stored words.
  - Release is synchronous to the next rising edge.
- Read accepted: rd_en && !empty.
- Write accepted: wr_en && (!full || read accepted).
  - When full, a simultaneous read and write both complete; count is unchanged.
- Empty with wr_en && rd_en: write accepted, read rejected, underflow pulses, count becomes 1. No fall-through path.
- Write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
- Read latency is 1 cycle:
  - On the accepting edge, data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; data_valid=1 for that cycle.
  - Otherwise data_valid=0 and data_out holds its last value.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- All flags are registered and computed from next-count, so they change on the same edge as count. There is no combinational path from inputs to outputs.
- overflow: 1 for exactly the cycle after an edge where wr_en=1 and the write was rejected. Pointers, count and memory are unaffected.
- underflow: 1 for exactly the cycle after an edge where rd_en=1 and the read was rejected. data_out holds its value; data_valid=0.
- Pointer wrap-around is transparent; FIFO order is preserved across any number of wraps.
- Elaboration checks (error on violation):
  - DEPTH == 2**ADDR
  - 0 < AE_LEVEL < AF_LEVEL < DEPTH
- There is no state machine beyond the pointer/count registers.

Test Plan:
1. Drive reset=0 between clock edges with count=5 -> outputs change immediately: count=0, empty=1, almost_empty=1, full=0, data_out=0, data_valid=0.
2. After reset, write 0x10..0x1F on 16 consecutive edges -> almost_empty drops when count=3; almost_full rises when count=14; full=1 with count=16 after the 16th edge. A 17th write of 0xAA -> overflow=1 for one cycle, count stays 16, 0xAA is never read.
3. From full, read 16 times -> data_out is 0x10..0x1F in order, each valid the cycle after its read edge with data_valid=1; empty=1 after the last read. A 17th read -> underflow=1 for one cycle, data_valid=0, data_out holds 0x1F.
4. Full with data 0x10..0x1F, assert wr_en=rd_en=1 with data_in=0x55 for one edge -> data_out=0x10, count=16, full stays 1, overflow=0. The next 15 reads return 0x11..0x1F, then the 16th returns 0x55.
5. Empty, assert wr_en=rd_en=1 with data_in=0x33 -> count=1, empty=0, underflow=1 for one cycle, data_valid=0. The next read returns 0x33.
6. Wrap and recovery:
   - Loop 3 times: write 12 words, then read 12 words, with incrementing data -> every read matches write order across pointer wrap, and count returns to 0 each time.
   - Then write 5 words, pulse reset, write 0x77, read once -> data_out=0x77 and empty=1.
